// File: rtl/cond_sum_subtractor_pipe.sv
// rtl/cond_sum_subtractor_pipe.sv - 2-stage conditional-sum subtractor (a - b - bin) with valid/ready.
// Optional macro CSS_SATURATE_EN: clamp diff to the signed limit on overflow.
module cond_sum_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int H = WIDTH / 2;

  logic         s1_valid;
  logic [H-1:0] lo_sum;
  logic         c_lo;
  logic [H:0]   hi0;
  logic [H:0]   hi1;
  logic         a_msb;
  logic         b_msb;

  logic s1_load;
  logic s2_load;

  assign in_ready = ~s1_valid | ~out_valid | out_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid & (~out_valid | out_ready);

  // Subtraction as a + ~b + ~bin; high half precomputed for both carry-ins.
  logic [H:0] lo_full;
  logic [H:0] hi0_c;
  logic [H:0] hi1_c;

  assign lo_full = {1'b0, a[H-1:0]} + {1'b0, ~b[H-1:0]} + {{H{1'b0}}, ~bin};
  assign hi0_c   = {1'b0, a[WIDTH-1:H]} + {1'b0, ~b[WIDTH-1:H]};
  assign hi1_c   = hi0_c + {{H{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      lo_sum   <= '0;
      c_lo     <= 1'b0;
      hi0      <= '0;
      hi1      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        lo_sum   <= lo_full[H-1:0];
        c_lo     <= lo_full[H];
        hi0      <= hi0_c;
        hi1      <= hi1_c;
        a_msb    <= a[WIDTH-1];
        b_msb    <= b[WIDTH-1];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 selects the high half by the low carry: a mux, not a ripple.
  logic [H:0]       high;
  logic [WIDTH-1:0] diff_raw;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;

  assign high     = c_lo ? hi1 : hi0;
  assign diff_raw = {high[H-1:0], lo_sum};
  assign ovf_next = (a_msb != b_msb) & (diff_raw[WIDTH-1] != a_msb);

`ifdef CSS_SATURATE_EN
  always_comb begin
    diff_next = diff_raw;
    if (ovf_next)
      diff_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign diff_next = diff_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        diff      <= diff_next;
        bout      <= ~high[H];
        ovf       <= ovf_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cond_sum_subtractor_pipe.sv
// tb/tb_cond_sum_subtractor_pipe.sv - self-checking bench for cond_sum_subtractor_pipe (WIDTH=16).
module tb_cond_sum_subtractor_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  cond_sum_subtractor_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff_wrap;
    logic [15:0] diff_sat;
    logic        bout;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  bit   consec = 0;
  bit   have_prev = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    exp_t        m;
    logic [16:0] r;
    r      = {1'b0, ma} - {1'b0, mb} - {16'b0, mbin};
    m.diff = r[15:0];
    m.bout = r[16];
    m.ovf  = (ma[15] != mb[15]) && (r[15] != ma[15]);
`ifdef CSS_SATURATE_EN
    if (m.ovf) m.diff = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return m;
  endfunction

  // Scoreboard consumer: a transfer is due at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_output", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("diff", 32'(diff), 32'(mon_e.diff));
        check("bout", 32'(bout), 32'(mon_e.bout));
        check("ovf",  32'(ovf),  32'(mon_e.ovf));
        if (consec) begin
          if (have_prev) check("consecutive_out", 32'(cyc), 32'(prev_cyc + 1));
          prev_cyc  = cyc;
          have_prev = 1;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input exp_t e, output int waits);
    bit acc;
    waits    = 0;
    in_valid = 1'b1;
    a = ta; b = tb; bin = tbin;
    acc = 0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    if (!acc) check("send_timeout", 32'(waits), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[11];
  int   w;
  exp_t e;
  logic [15:0] held;

  initial begin
    vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0};
    vecs[1]  = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{16'h7FFF, 16'h0000, 1'b1, 16'h7FFE, 16'h7FFE, 1'b0, 1'b0};

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors
    foreach (vecs[i]) begin
`ifdef CSS_SATURATE_EN
      e = '{vecs[i].diff_sat, vecs[i].bout, vecs[i].ovf};
`else
      e = '{vecs[i].diff_wrap, vecs[i].bout, vecs[i].ovf};
`endif
      send(vecs[i].a, vecs[i].b, vecs[i].bin, e, w);
    end
    drain();

    // Two-cycle latency
    send(16'h0005, 16'h0003, 1'b0, model(16'h0005, 16'h0003, 1'b0), w);
    check("latency_1cyc_not_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_2cyc_valid", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back throughput
    consec = 1; have_prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'(i * 16'h1111), 16'h0101, 1'b0, model(16'(i * 16'h1111), 16'h0101, 1'b0), w);
      check("b2b_no_wait", 32'(w), 32'd0);
    end
    drain();
    consec = 0;

    // Backpressure: two accepted, third stalls, outputs held stable
    out_ready = 1'b0;
    send(16'h4000, 16'h1000, 1'b0, model(16'h4000, 16'h1000, 1'b0), w);
    send(16'h0010, 16'h0020, 1'b1, model(16'h0010, 16'h0020, 1'b1), w);
    in_valid = 1'b1; a = 16'h8000; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    held = diff;
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_diff_stable", 32'(diff), 32'(held));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h8000, 16'h0001, 1'b0, model(16'h8000, 16'h0001, 1'b0), w);
    drain();

    // Reset mid-flight discards everything
    send(16'h1111, 16'h0001, 1'b0, model(16'h1111, 16'h0001, 1'b0), w);
    send(16'h2222, 16'h0002, 1'b0, model(16'h2222, 16'h0002, 1'b0), w);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    send(16'h0300, 16'h0100, 1'b0, model(16'h0300, 16'h0100, 1'b0), w);
    drain();
    repeat (3) @(posedge clk);
    #1 check("final_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
